// File: rtl/pio_axil_master_if.sv
// ============================================================================
// Module   : pio_axil_master_if
// Purpose  : AXI4-Lite bus bundle between the PIO master and the user fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pio_axil_master_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

`default_nettype wire

// File: rtl/pio_axil_master.sv
// ============================================================================
// Module   : pio_axil_master
// Purpose  : Turns single-DW PIO read/write requests into AXI4-Lite accesses.
//            Optional watchdog enabled by defining PIO_AXIL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_axil_master #(
  parameter logic [31:0] AXI_ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               rd_en,
  input  wire        [31:0] rd_addr,
  input  wire        [3:0]  rd_be,
  output logic       [31:0] rd_data,
  output logic              rd_data_valid,
  input  wire               compl_done,
  input  wire               wr_en,
  input  wire        [31:0] wr_addr,
  input  wire        [3:0]  wr_be,
  input  wire        [31:0] wr_data,
  output logic              wr_busy,
  output logic              err_pulse,
  pio_axil_master_if.master m_axil
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_pend_vld;
  logic [29:0] r_pend_word;
  logic        r_cap_vld;
  logic        r_cap_err;
  logic [31:0] r_cap_data;

  logic        w_idle;
  logic        w_wr_take;
  logic        w_wr_go;
  logic        w_rd_go;
  logic [29:0] w_rd_word;
  logic        w_wr_hs_done;
  logic        w_b_done;
  logic        w_ar_done;
  logic        w_r_done;
  logic        w_tmo;
  logic        w_unused;

  assign m_axil.awprot = 3'b000;
  assign m_axil.arprot = 3'b000;

  assign w_idle    = (r_state == S_IDLE);
  // A write is accepted whenever none is outstanding; it is issued once IDLE.
  assign w_wr_take = wr_en && !wr_busy;
  assign w_wr_go   = w_idle && (w_wr_take || wr_busy);
  assign w_rd_go   = w_idle && !w_wr_go && (r_pend_vld || rd_en);
  assign w_rd_word = r_pend_vld ? r_pend_word : rd_addr[31:2];

  assign w_wr_hs_done = (r_state == S_WR_REQ) &&
                        (!m_axil.awvalid || m_axil.awready) &&
                        (!m_axil.wvalid  || m_axil.wready);
  assign w_b_done     = (r_state == S_WR_RESP) && m_axil.bvalid;
  assign w_ar_done    = (r_state == S_RD_REQ)  && m_axil.arready;
  assign w_r_done     = (r_state == S_RD_RESP) && m_axil.rvalid;

  assign w_unused = &{1'b0, rd_be, rd_addr[1:0], wr_addr[1:0]};

`ifdef PIO_AXIL_TIMEOUT_EN
  localparam logic [31:0] c_tmo_last = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_tmo_cnt;
  logic        w_state_chg;

  assign w_state_chg = w_wr_hs_done || w_b_done || w_ar_done || w_r_done;
  // A handshake completing on the final cycle takes precedence over the abort.
  assign w_tmo = !w_idle && !w_state_chg && (r_tmo_cnt == c_tmo_last);

  always_ff @(posedge clk) begin
    if (!rst_n || w_idle || w_state_chg || w_tmo)
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pend_vld     <= 1'b0;
      r_pend_word    <= '0;
      r_cap_vld      <= 1'b0;
      r_cap_err      <= 1'b0;
      r_cap_data     <= '0;
      rd_data        <= '0;
      rd_data_valid  <= 1'b0;
      wr_busy        <= 1'b0;
      err_pulse      <= 1'b0;
      m_axil.awaddr  <= '0;
      m_axil.awvalid <= 1'b0;
      m_axil.wdata   <= '0;
      m_axil.wstrb   <= '0;
      m_axil.wvalid  <= 1'b0;
      m_axil.bready  <= 1'b0;
      m_axil.araddr  <= '0;
      m_axil.arvalid <= 1'b0;
      m_axil.rready  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;

      if (w_wr_take) begin
        wr_busy       <= 1'b1;
        m_axil.awaddr <= {wr_addr[31:2], 2'b00} + AXI_ADDR_BASE;
        m_axil.wdata  <= wr_data;
        m_axil.wstrb  <= wr_be;
      end

      // Issuing from the slot frees it, so a same-cycle rd_en can refill it.
      if (w_rd_go) begin
        r_pend_vld  <= r_pend_vld && rd_en;
        r_pend_word <= rd_addr[31:2];
      end else if (rd_en && !r_pend_vld) begin
        r_pend_vld  <= 1'b1;
        r_pend_word <= rd_addr[31:2];
      end

      if (r_cap_vld) begin
        rd_data       <= r_cap_err ? ERR_DATA : r_cap_data;
        rd_data_valid <= 1'b1;
        err_pulse     <= r_cap_err;
        r_cap_vld     <= 1'b0;
      end else if (compl_done || w_rd_go) begin
        rd_data_valid <= 1'b0;
      end

      if (w_tmo) begin
        m_axil.awvalid <= 1'b0;
        m_axil.wvalid  <= 1'b0;
        m_axil.bready  <= 1'b0;
        m_axil.arvalid <= 1'b0;
        m_axil.rready  <= 1'b0;
        r_state        <= S_IDLE;
        if ((r_state == S_WR_REQ) || (r_state == S_WR_RESP)) begin
          wr_busy   <= 1'b0;
          err_pulse <= 1'b1;
        end else begin
          r_cap_vld <= 1'b1;
          r_cap_err <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_wr_go) begin
              m_axil.awvalid <= 1'b1;
              m_axil.wvalid  <= 1'b1;
              r_state        <= S_WR_REQ;
            end else if (w_rd_go) begin
              m_axil.araddr  <= {w_rd_word, 2'b00} + AXI_ADDR_BASE;
              m_axil.arvalid <= 1'b1;
              r_state        <= S_RD_REQ;
            end
          end
          S_WR_REQ: begin
            if (m_axil.awready) m_axil.awvalid <= 1'b0;
            if (m_axil.wready)  m_axil.wvalid  <= 1'b0;
            if (w_wr_hs_done) begin
              m_axil.bready <= 1'b1;
              r_state       <= S_WR_RESP;
            end
          end
          S_WR_RESP: begin
            if (w_b_done) begin
              m_axil.bready <= 1'b0;
              wr_busy       <= 1'b0;
              err_pulse     <= (m_axil.bresp != 2'b00);
              r_state       <= S_IDLE;
            end
          end
          S_RD_REQ: begin
            if (w_ar_done) begin
              m_axil.arvalid <= 1'b0;
              m_axil.rready  <= 1'b1;
              r_state        <= S_RD_RESP;
            end
          end
          S_RD_RESP: begin
            if (w_r_done) begin
              m_axil.rready <= 1'b0;
              r_cap_vld     <= 1'b1;
              r_cap_err     <= (m_axil.rresp != 2'b00);
              r_cap_data    <= m_axil.rdata;
              r_state       <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pio_axil_master.sv
// ============================================================================
// Module   : tb_pio_axil_master
// Purpose  : Self-checking bench for pio_axil_master with an AXI4-Lite slave
//            model and a memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_axil_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [3:0]  rd_be = '0;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        compl_done = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        wr_busy;
  logic        err_pulse;

  pio_axil_master_if bus ();

  pio_axil_master #(
    .AXI_ADDR_BASE (BASE),
    .ERR_DATA      (ERRD),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_be        (rd_be),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .compl_done   (compl_done),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_be        (wr_be),
    .wr_data      (wr_data),
    .wr_busy      (wr_busy),
    .err_pulse    (err_pulse),
    .m_axil       (bus)
  );

  always #5 clk = ~clk;

  // ---------------- slave configuration and bookkeeping ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic        ar_hold = 1'b0, r_hold = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  int          aw_wait, w_wait, ar_wait;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_errp = 0;
  logic [31:0] last_araddr;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;
  logic [31:0] slv_mem [int unsigned];
  logic [31:0] mdl_mem [int unsigned];

  int n_assert = 0;
  int n_fail = 0;

  assign bus.awready = bus.awvalid && (aw_wait >= aw_dly);
  assign bus.wready  = bus.wvalid && (w_wait >= w_dly);
  assign bus.arready = bus.arvalid && !ar_hold && (ar_wait >= ar_dly);

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
    end else begin
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
      if (bus.awvalid && bus.awready) begin
        aw_got <= 1'b1; aw_a <= bus.awaddr; n_aw <= n_aw + 1;
      end
      if (bus.wvalid && bus.wready) begin
        w_got <= 1'b1; w_d <= bus.wdata; w_s <= bus.wstrb; n_w <= n_w + 1;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0; n_b <= n_b + 1;
      end else if (aw_got && w_got && !bus.bvalid) begin
        logic [31:0] v;
        v = slv_rd(aw_a);
        for (int i = 0; i < 4; i++)
          if (w_s[i]) v[8*i +: 8] = w_d[8*i +: 8];
        slv_mem[aw_a] = v;
        bus.bvalid <= 1'b1; bus.bresp <= bresp_cfg;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      ar_wait <= 0; bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
    end else begin
      ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        n_ar        <= n_ar + 1;
        last_araddr <= bus.araddr;
        bus.rvalid  <= !r_hold;
        bus.rdata   <= slv_rd(bus.araddr);
        bus.rresp   <= rresp_cfg;
      end
    end
  end

  always @(negedge clk) if (err_pulse === 1'b1) n_errp <= n_errp + 1;

  // ---------------- reference model: word memory seen through the bridge ----------------
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) + BASE;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    logic [31:0] k;
    k = map_addr(a);
    return mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    mdl_mem[map_addr(a)] = (mdl_read(a) & ~mask) | (d & mask);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    slv_mem[map_addr(a)] = d;
    mdl_mem[map_addr(a)] = d;
  endtask

  // ---------------- checking and stimulus helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rd(input logic [31:0] a);
    rd_addr = a; rd_be = 4'($urandom_range(0, 15)); rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_addr = a; wr_data = d; wr_be = be; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic release_rd();
    compl_done = 1'b1;
    @(negedge clk);
    compl_done = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 80 && rd_data_valid !== 1'b1; i++) @(negedge clk);
    check(tag, 32'(rd_data_valid), 32'd1);
  endtask

  task automatic wait_wr_idle(input string tag);
    for (int i = 0; i < 80 && wr_busy !== 1'b0; i++) @(negedge clk);
    check(tag, 32'(wr_busy), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb0, prev_nb, aw0, w0, ar0, errp0, exp_err;
    logic [31:0] a, d;
    logic [3:0]  be;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_wr_busy", 32'(wr_busy), 32'd0);
    check("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, err_pulse}), 32'd0);
    check("rst_prot", 32'({bus.awprot, bus.arprot}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- single read, zero-wait slave ----
    preload(32'h104, 32'hCAFE_F00D);
    pulse_rd(32'h0000_0104);
    check("rd_arvalid_T1", 32'(bus.arvalid), 32'd1);
    check("rd_araddr", bus.araddr, 32'h4000_0104);
    @(negedge clk);
    check("rd_valid_T2", 32'(rd_data_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_T3", 32'(rd_data_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_T4", 32'(rd_data_valid), 32'd1);
    check("rd_data_T4", rd_data, 32'hCAFE_F00D);
    repeat (5) @(negedge clk);
    check("rd_hold_valid", 32'(rd_data_valid), 32'd1);
    check("rd_hold_data", rd_data, 32'hCAFE_F00D);
    release_rd();
    check("rd_release", 32'(rd_data_valid), 32'd0);

    // ---- write, W handshake 3 cycles before AW ----
    aw_dly = 3; w_dly = 0;
    nb0 = n_b; aw0 = n_aw; w0 = n_w;
    pulse_wr(32'h10, 32'h1234_5678, 4'b0011);
    mdl_write(32'h10, 32'h1234_5678, 4'b0011);
    check("wr_busy_set", 32'(wr_busy), 32'd1);
    check("wr_awaddr", bus.awaddr, 32'h4000_0010);
    check("wr_wstrb", 32'(bus.wstrb), 32'h3);
    check("wr_wdata", bus.wdata, 32'h1234_5678);
    @(negedge clk);
    check("wr_w_first", 32'({bus.awvalid, bus.wvalid}), 32'b10);
    prev_nb = n_b;
    for (int i = 0; i < 80 && wr_busy === 1'b1; i++) begin
      prev_nb = n_b;
      @(negedge clk);
    end
    check("wr_busy_clear", 32'(wr_busy), 32'd0);
    check("wr_no_b_while_busy", 32'(prev_nb), 32'(nb0));
    check("wr_b_at_busy_fall", 32'(n_b), 32'(nb0 + 1));
    repeat (2) @(negedge clk);
    check("wr_one_aw", 32'(n_aw), 32'(aw0 + 1));
    check("wr_one_w", 32'(n_w), 32'(w0 + 1));
    aw_dly = 0;
    pulse_rd(32'h10);
    wait_valid("wr_readback_valid");
    check("wr_readback_data", rd_data, mdl_read(32'h10));
    release_rd();

    // ---- write and read in the same cycle: write goes first ----
    ar0 = n_ar;
    d = $urandom;
    wr_addr = 32'h20; wr_data = d; wr_be = 4'hF; wr_en = 1'b1;
    rd_addr = 32'h20; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    mdl_write(32'h20, d, 4'hF);
    check("ord_aw_first", 32'({bus.awvalid, bus.arvalid}), 32'b10);
    wait_wr_idle("ord_wr_done");
    check("ord_no_ar_before_b", 32'(n_ar), 32'(ar0));
    @(negedge clk);
    check("ord_ar_after_b", 32'(bus.arvalid), 32'd1);
    wait_valid("ord_rd_valid");
    check("ord_rd_data", rd_data, mdl_read(32'h20));
    release_rd();

    // ---- read error response ----
    errp0 = n_errp;
    rresp_cfg = 2'b10;
    pulse_rd(32'h60);
    wait_valid("rerr_valid");
    check("rerr_data", rd_data, ERRD);
    check("rerr_pulse_hi", 32'(err_pulse), 32'd1);
    @(negedge clk);
    check("rerr_pulse_lo", 32'(err_pulse), 32'd0);
    check("rerr_pulse_count", 32'(n_errp - errp0), 32'd1);
    rresp_cfg = 2'b00;
    release_rd();

    // ---- reads during a write: one pending, second dropped ----
    preload(32'h40, 32'h1111_0040);
    preload(32'h50, 32'h2222_0050);
    aw_dly = 6;
    ar0 = n_ar;
    pulse_wr(32'h30, 32'hA5A5_0030, 4'hF);
    mdl_write(32'h30, 32'hA5A5_0030, 4'hF);
    pulse_rd(32'h40);
    @(negedge clk);
    pulse_rd(32'h50);
    wait_wr_idle("pend_wr_done");
    wait_valid("pend_rd_valid");
    repeat (10) @(negedge clk);
    check("pend_one_ar", 32'(n_ar), 32'(ar0 + 1));
    check("pend_araddr", last_araddr, map_addr(32'h40));
    check("pend_rd_data", rd_data, mdl_read(32'h40));
    aw_dly = 0;
    release_rd();

    // ---- randomized traffic against the memory model ----
    errp0 = n_errp;
    exp_err = 0;
    for (int k = 0; k < 24; k++) begin
      aw_dly = int'($urandom_range(0, 3));
      w_dly  = int'($urandom_range(0, 3));
      ar_dly = int'($urandom_range(0, 3));
      a = 32'h200 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        be = 4'($urandom_range(0, 15));
        bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        if (bresp_cfg != 2'b00) exp_err++;
        pulse_wr(a, d, be);
        mdl_write(a, d, be);
        wait_wr_idle("rnd_wr_done");
      end else begin
        pulse_rd(a);
        wait_valid("rnd_rd_valid");
        check("rnd_rd_data", rd_data, mdl_read(a));
        release_rd();
      end
    end
    bresp_cfg = 2'b00;
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    repeat (2) @(negedge clk);
    check("rnd_err_count", 32'(n_errp - errp0), 32'(exp_err));

`ifdef PIO_AXIL_TIMEOUT_EN
    // ---- watchdog abort and reset during RD_RESP ----
    begin
      int cnt;
      ar_hold = 1'b1;
      pulse_rd(32'h70);
      cnt = 0;
      while (bus.arvalid === 1'b1 && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      check("tmo_arvalid_cycles", 32'(cnt), 32'd16);
      wait_valid("tmo_rd_valid");
      check("tmo_rd_data", rd_data, ERRD);
      check("tmo_err_pulse", 32'(err_pulse), 32'd1);
      ar_hold = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      r_hold = 1'b1;
      pulse_rd(32'h74);
      for (int i = 0; i < 40 && bus.rready !== 1'b1; i++) @(negedge clk);
      check("mid_rready_up", 32'(bus.rready), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_rready", 32'(bus.rready), 32'd0);
      check("mid_rst_valid", 32'(rd_data_valid), 32'd0);
      rst_n = 1'b1;
      r_hold = 1'b0;
      repeat (2) @(negedge clk);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pio_axil_master.md
Name: pio_axil_master

Overview:
- Memory-side stage of the PIO path. Consumes single-DW read requests (rd_en/rd_addr/rd_be) issued alongside the completion TX engine, and single-DW write requests from the RX engine.
- Converts each request into one AXI4-Lite transaction on the user fabric.
- Returns read data to the TX engine as a held rd_data/rd_data_valid pair.
- Handles one outstanding transaction at a time, with a one-deep pending-read slot.

Parameters:
- AXI_ADDR_BASE, 32'h0000_0000: added to every request address before issue on araddr/awaddr.
- ERR_DATA, 32'hFFFF_FFFF: value returned on rd_data for an error response or an aborted read.
- TIMEOUT_CYCLES, 1024: watchdog limit in clk cycles. Only used when PIO_AXIL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rd_en  in  1  one-cycle read request strobe
- rd_addr  in  32  read byte address; bits [1:0] ignored
- rd_be  in  4  read byte enables; sampled with rd_en, not used on the bus
- rd_data  out  32  read data to the TX engine
- rd_data_valid  out  1  rd_data valid, held until released
- compl_done  in  1  TX engine completion-sent pulse; releases rd_data_valid
- wr_en  in  1  one-cycle write request strobe
- wr_addr  in  32  write byte address; bits [1:0] ignored
- wr_be  in  4  write byte enables
- wr_data  in  32  write data
- wr_busy  out  1  write in progress
- m_axil_awaddr  out  32; m_axil_awvalid  out  1; m_axil_awready  in  1
- m_axil_wdata  out  32; m_axil_wstrb  out  4; m_axil_wvalid  out  1; m_axil_wready  in  1
- m_axil_bresp  in  2; m_axil_bvalid  in  1; m_axil_bready  out  1
- m_axil_araddr  out  32; m_axil_arvalid  out  1; m_axil_arready  in  1
- m_axil_rdata  in  32; m_axil_rresp  in  2; m_axil_rvalid  in  1; m_axil_rready  out  1
- m_axil_awprot, m_axil_arprot  out  3  tied to 3'b000
- err_pulse  out  1  one-cycle pulse on any non-OKAY BRESP or RRESP

Behaviour:
- Reset values: all outputs 0, rd_data 0, state IDLE, pending slot empty.
- Address mapping: bus address = {req_addr[31:2],2'b00} + AXI_BASE, computed mod 2^32 (wraps).

State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE, write selected: load awaddr/wdata/wstrb, assert awvalid and wvalid, go to WR_REQ.
- IDLE, read selected: load araddr, assert arvalid, go to RD_REQ.
- Arbitration in IDLE: a write (wr_en this cycle) always wins over a read (rd_en this cycle or the pending slot). This keeps posted writes ahead of later reads.
- WR_REQ: awvalid drops on the cycle after the AW handshake; wvalid drops on the cycle after the W handshake. The two handshakes are independent and may occur in either order or together. When both are done, assert bready and go to WR_RESP.
- WR_RESP: on bvalid&&bready, drop bready, clear wr_busy, go to IDLE. If bresp!=2'b00, pulse err_pulse.
- RD_REQ: on arready, drop arvalid, assert rready, go to RD_RESP.
- RD_RESP: on rvalid&&rready, drop rready and go to IDLE. On the next edge, rd_data takes rdata (or ERR_DATA if rresp!=OKAY, which also pulses err_pulse) and rd_data_valid goes to 1.

Latency and request rules:
- Request sampled at edge T: arvalid/awvalid is 1 from T+1. Zero-wait slave gives rd_data_valid at T+4.
- wr_busy: set on the edge that samples wr_en, cleared on the edge completing B. Upstream must not assert wr_en while wr_busy=1; such a wr_en is ignored.
- rd_en while not IDLE: captured in a one-deep pending slot (address). A second rd_en while the slot is full is dropped.

rd_data_valid hold and release:
- Once set, rd_data_valid stays 1 and rd_data stays stable until compl_done=1 or a new read is issued, whichever comes first.
- compl_done and the R-handshake register update on the same edge: the new data wins and valid stays 1.

Reset mid-transaction: all valids, readies and state return to reset values at once; the pending slot is cleared.

Optional Feature:
- PIO_AXIL_TIMEOUT_EN defined: a counter runs in WR_REQ, WR_RESP, RD_REQ and RD_RESP, and clears on each state change.
- On reaching TIMEOUT_CYCLES, all valids/readies drop and the state returns to IDLE. A write clears wr_busy; a read returns ERR_DATA with rd_data_valid=1. err_pulse fires for one cycle.
- The fabric must be reset after a timeout.
- PIO_AXIL_TIMEOUT_EN undefined: no counter; the block waits indefinitely.

Test Plan:
- rd_en, rd_addr=32'h0000_0104, AXI_BASE=32'h4000_0000, zero-wait slave returns rdata=32'hCAFE_F00D -> araddr=32'h4000_0104; rd_data_valid=1 at T+4 with 32'hCAFE_F00D; held until compl_done, then 0.
- wr_en, wr_addr=32'h10, wr_data=32'h1234_5678, wr_be=4'b0011; wready asserted 3 cycles before awready -> wstrb=4'b0011, both handshakes complete once, wr_busy high until the B edge.
- wr_en and rd_en in the same cycle -> AW/W issued first; AR issued only after B completes; read data returned afterwards.
- rresp=2'b10 -> rd_data=32'hFFFF_FFFF, rd_data_valid=1, err_pulse exactly 1 cycle.
- rd_en during an active write, plus a second rd_en -> first read issued after B; second dropped; exactly one AR.
- With PIO_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready held 0 -> arvalid drops after 16 cycles; rd_data=32'hFFFF_FFFF; err_pulse=1; reset mid-RD_RESP clears rready and rd_data_valid immediately.
